// File: rtl/spare_pkg.sv
// Shared constants and decoded-entry layout for the spare-candidate consumer.
package spare_pkg;

    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam int unsigned TOTAL_S12 = 70;
    localparam int unsigned TOTAL_S3  = 210;

    localparam int unsigned ERR_POPCNT = 0;
    localparam int unsigned ERR_ORDER  = 1;
    localparam int unsigned ERR_RLSS   = 2;
    localparam int unsigned ERR_OVF    = 3;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned ENTRY_W = 4 * IDX_W + ROW_W;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 4;

    // Field order doubles as the enumeration-order key {i,j,k,p,row}.
    typedef struct packed {
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] p;
        logic [ROW_W-1:0] row;
    } cand_t;

endpackage

// File: rtl/spare_cand_fifo.sv
// Synchronous FIFO holding decoded candidates; push while full succeeds only with a pop.
module spare_cand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; empty pointers mask stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spare_signal_decoder.sv
// Decodes DSSS/RLSS candidates, checks format and enumeration order, counts to the
// expected total and buffers decoded entries for a backpressuring consumer.
module spare_signal_decoder
    import spare_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        spare_struct_type,
    input  logic [7:0]        DSSS,
    input  logic [3:0]        RLSS,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  idx_i,
    output logic [IDX_W-1:0]  idx_j,
    output logic [IDX_W-1:0]  idx_k,
    output logic [IDX_W-1:0]  idx_p,
    output logic [ROW_W-1:0]  row_idx,
    output logic [CNT_W-1:0]  cand_count,
    output logic              done,
    output logic [ERR_W-1:0]  err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [1:0]         mode, mode_nxt;
    cand_t              prev_key, prev_key_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic               done_nxt;
    logic [CNT_W-1:0]   total;

    logic               cand;
    cand_t              dec;
    logic [3:0]         nset;
    logic               rlss_bad;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    cand_t              head;

    assign cand = (spare_struct_type != 2'b00) && (DSSS != 8'h00);
    assign pop  = !fifo_empty && out_ready;

    // First four set bits from the MSB; nset doubles as the popcount.
    always_comb begin
        dec.i = '0;
        dec.j = '0;
        dec.k = '0;
        dec.p = '0;
        nset  = '0;
        for (int b = 7; b >= 0; b--) begin
            if (DSSS[b]) begin
                case (nset)
                    4'd0:    dec.i = IDX_W'(b);
                    4'd1:    dec.j = IDX_W'(b);
                    4'd2:    dec.k = IDX_W'(b);
                    4'd3:    dec.p = IDX_W'(b);
                    default: ;
                endcase
                nset = nset + 4'd1;
            end
        end
    end

    always_comb begin
        dec.row  = '0;
        rlss_bad = 1'b0;
        if (spare_struct_type == S3) begin
            if      (RLSS[3]) dec.row = 2'd3;
            else if (RLSS[2]) dec.row = 2'd2;
            else if (RLSS[1]) dec.row = 2'd1;
            rlss_bad = !((RLSS == 4'b1000) || (RLSS == 4'b0100) || (RLSS == 4'b0010));
        end else begin
            rlss_bad = (RLSS != 4'b0000);
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode;
        prev_key_nxt = prev_key;
        count_nxt    = cand_count;
        err_nxt      = err;
        done_nxt     = done;
        total        = CNT_W'(TOTAL_S12);
        if (cand) begin
            if (state == ST_IDLE) begin
                mode_nxt = spare_struct_type;
            end else begin
                if (spare_struct_type != mode) err_nxt[ERR_ORDER] = 1'b1;
                if (dec >= prev_key)           err_nxt[ERR_ORDER] = 1'b1;
            end
            if (state == ST_DONE)              err_nxt[ERR_ORDER]  = 1'b1;
            if (nset != 4'd4)                  err_nxt[ERR_POPCNT] = 1'b1;
            if (rlss_bad)                      err_nxt[ERR_RLSS]   = 1'b1;
            if (fifo_full && !pop)             err_nxt[ERR_OVF]    = 1'b1;
            prev_key_nxt = dec;
            if (cand_count != '1) count_nxt = cand_count + CNT_W'(1);
            if (mode_nxt == S3) total = CNT_W'(TOTAL_S3);
            if (state != ST_DONE) begin
                state_nxt = (count_nxt == total) ? ST_DONE : ST_RUN;
            end
        end
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode       <= 2'b00;
            prev_key   <= '0;
            cand_count <= '0;
            err        <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            prev_key   <= prev_key_nxt;
            cand_count <= count_nxt;
            err        <= err_nxt;
            done       <= done_nxt;
        end
    end

    spare_cand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cand),
        .pop   (pop),
        .din   (dec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign idx_i     = fifo_empty ? '0 : head.i;
    assign idx_j     = fifo_empty ? '0 : head.j;
    assign idx_k     = fifo_empty ? '0 : head.k;
    assign idx_p     = fifo_empty ? '0 : head.p;
    assign row_idx   = fifo_empty ? '0 : head.row;

endmodule

// File: tb/tb_spare_signal_decoder.sv
// Scoreboard bench: a behavioural model predicts status and decoded entries;
// a negedge monitor compares each entry as the consumer takes it.
module tb_spare_signal_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] spare_struct_type;
    logic [7:0] DSSS;
    logic [3:0] RLSS;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] idx_i, idx_j, idx_k, idx_p;
    logic [1:0] row_idx;
    logic [7:0] cand_count;
    logic       done;
    logic [3:0] err;

    spare_signal_decoder #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .spare_struct_type (spare_struct_type),
        .DSSS              (DSSS),
        .RLSS              (RLSS),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .idx_i             (idx_i),
        .idx_j             (idx_j),
        .idx_k             (idx_k),
        .idx_p             (idx_p),
        .row_idx           (row_idx),
        .cand_count        (cand_count),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int j;
        int k;
        int p;
        int row;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int   m_count;
    int   m_err;
    bit   m_done;
    int   m_mode;
    int   m_prev;
    int   m_occ;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_err   = 0;
        m_done  = 0;
        m_mode  = 0;
        m_prev  = 0;
        m_occ   = 0;
        exp_q.delete();
    endtask

    // One clock cycle: check the state left by the previous edge, then drive and predict.
    task automatic step(input bit r, input int t, input int d, input int rl, input bit rdy);
        int   pos[4];
        int   n;
        int   row;
        bit   bad;
        int   key;
        int   total;
        bit   popped;
        ent_t e;
        @(posedge clk);
        #1;
        chk("cand_count", int'(cand_count), m_count);
        chk("err", int'(err), m_err);
        chk("done", int'(done), int'(m_done));
        chk("out_valid", int'(out_valid), (m_occ > 0) ? 1 : 0);
        if (m_occ == 0)
            chk("empty_outputs", int'({idx_i, idx_j, idx_k, idx_p, row_idx}), 0);
        rst               = r;
        spare_struct_type = 2'(t);
        DSSS              = 8'(d);
        RLSS              = 4'(rl);
        out_ready         = rdy;
        if (r) begin
            model_reset();
            return;
        end
        popped = (m_occ > 0) && rdy;
        if (t != 0 && d != 0) begin
            pos = '{0, 0, 0, 0};
            n = 0;
            for (int b = 7; b >= 0; b--) begin
                if ((d >> b) & 1) begin
                    if (n < 4) pos[n] = b;
                    n++;
                end
            end
            row = 0;
            if (t == 3) begin
                for (int b = 0; b < 4; b++) if ((rl >> b) & 1) row = b;
                bad = !(rl == 2 || rl == 4 || rl == 8);
            end else begin
                bad = (rl != 0);
            end
            key = (((pos[0] * 8 + pos[1]) * 8 + pos[2]) * 8 + pos[3]) * 4 + row;
            if (n != 4) m_err |= 1;
            if (bad)    m_err |= 4;
            if (m_mode == 0) m_mode = t;
            else if (t != m_mode || key >= m_prev) m_err |= 2;
            if (m_done) m_err |= 2;
            m_prev = key;
            if (m_count < 255) m_count++;
            total = (m_mode == 3) ? 210 : 70;
            if (m_count == total) m_done = 1;
            if (m_occ < 4 || popped) begin
                e = '{pos[0], pos[1], pos[2], pos[3], row};
                exp_q.push_back(e);
                m_occ++;
            end else begin
                m_err |= 8;
            end
        end
        if (popped) m_occ--;
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("idx_i", int'(idx_i), e.i);
                chk("idx_j", int'(idx_j), e.j);
                chk("idx_k", int'(idx_k), e.k);
                chk("idx_p", int'(idx_p), e.p);
                chk("row_idx", int'(row_idx), e.row);
            end
        end
    end

    function automatic bit four_hot(input int v);
        return $countones(8'(v)) == 4;
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        spare_struct_type = 2'b00;
        DSSS = 8'h00;
        RLSS = 4'h0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) step(1, 0, 0, 0, 1);

        // Single S1 candidate
        step(0, 1, 8'hF0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Full S1 run then one extra candidate
        for (int v = 255; v > 0; v--) if (four_hot(v)) step(0, 1, v, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 8'hF0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // S3 row decode, then a repeated key
        step(0, 3, 8'hF0, 8, 1);
        step(0, 3, 8'hF0, 4, 1);
        step(0, 3, 8'hF0, 2, 1);
        step(0, 3, 8'hE8, 8, 1);
        step(0, 3, 8'hE8, 4, 1);
        step(0, 3, 8'hE8, 4, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Format errors
        step(0, 1, 8'h70, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 1, 8'hF0, 2, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 3, 8'hF0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Backpressure: six candidates into a four-deep buffer, then drain
        n = 0;
        for (int v = 255; v > 0; v--) begin
            if (four_hot(v) && n < 6) begin
                step(0, 1, v, 0, 0);
                n++;
            end
        end
        step(0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Reset mid-run, then a full S3 run with random backpressure and gaps
        n = 0;
        for (int v = 255; v > 0; v--) begin
            if (four_hot(v) && n < 30) begin
                step(0, 1, v, 0, 1);
                n++;
            end
        end
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int v = 255; v > 0; v--) begin
            if (four_hot(v)) begin
                for (int r = 3; r >= 1; r--) begin
                    if ($urandom_range(0, 4) == 0) step(0, 0, 0, 0, $urandom_range(0, 3) != 0);
                    step(0, 3, v, 1 << r, $urandom_range(0, 3) != 0);
                end
            end
        end
        repeat (6) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            int d;
            d = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 0) begin
                while (!four_hot(d)) d = $urandom_range(0, 255);
            end
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3), d,
                 $urandom_range(0, 15), $urandom_range(0, 2) != 0);
        end

        repeat (8) step(0, 0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
